pipe_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage core: drives stall (hold) and flush (load bubble) controls of
//  the PC, IF/ID, ID/EX and EX/MEM registers. Resolves load-use hazards, D-side memory waits, multi-cycle
//  MDU ops and EX-stage branch mispredicts. Owns the redirect handshake to fetch. Keeps a stall counter.

---
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall/flush control of the pipeline registers,
// hazard resolution, fetch redirect handshake, a saturating stall counter and an MDU timeout flag.
module pipe_ctrl #(
  parameter int PC_W    = 64,
  parameter int RD_W    = 5,
  parameter int MDU_TMO = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [RD_W-1:0] id_rs1,
  input  logic [RD_W-1:0] id_rs2,
  input  logic            id_rs1_ren,
  input  logic            id_rs2_ren,
  input  logic            ex_is_load,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_mispredict,
  input  logic [PC_W-1:0] ex_target_pc,
  input  logic            ex_mdu_start,
  input  logic            mdu_done,
  input  logic            mem_req,
  input  logic            mem_ready,
  input  logic            redirect_ready,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            idex_stall,
  output logic            exmem_stall,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            memwb_flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     stall_cycles,
  output logic            mdu_tmo_err
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT, REDIR} state_e;

  localparam int CNT_W = $clog2(MDU_TMO + 1);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(MDU_TMO);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;
  logic              mdu_tmo_err_q, mdu_tmo_err_d;
  logic              mem_block, mdu_block, load_use;

  always_comb begin
    mem_block = mem_req & ~mem_ready;
    mdu_block = ex_mdu_start & ~mdu_done;
    load_use  = ex_is_load & (ex_rd != '0) &
                ((id_rs1_ren & (id_rs1 == ex_rd)) | (id_rs2_ren & (id_rs2 == ex_rd)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      mdu_cnt_q      <= '0;
      redirect_pc_q  <= '0;
      stall_cycles_q <= '0;
      mdu_tmo_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      mdu_cnt_q      <= mdu_cnt_d;
      redirect_pc_q  <= redirect_pc_d;
      stall_cycles_q <= stall_cycles_d;
      mdu_tmo_err_q  <= mdu_tmo_err_d;
    end
  end

  // Mispredicts seen while waiting on MEM/MDU are ignored: EX is held and re-presents it later.
  always_comb begin
    state_d       = state_q;
    mdu_cnt_d     = mdu_cnt_q;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      RUN: begin
        if (mem_block) begin
          state_d = MEM_WAIT;
        end else if (mdu_block) begin
          state_d   = MDU_WAIT;
          mdu_cnt_d = '0;
        end else if (ex_mispredict) begin
          state_d       = REDIR;
          redirect_pc_d = ex_target_pc;
        end
      end
      MEM_WAIT: if (mem_ready) state_d = RUN;
      MDU_WAIT: begin
        if (mdu_done) begin
          state_d = RUN;
        end else if (mdu_cnt_q != TMO_CNT) begin
          mdu_cnt_d = mdu_cnt_q + 1'b1;
        end
      end
      REDIR: if (redirect_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
    mdu_tmo_err_d  = mdu_tmo_err_q | ((state_q == MDU_WAIT) && (mdu_cnt_d == TMO_CNT));
    stall_cycles_d = (pc_stall && (stall_cycles_q != '1)) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end

  // Stall and flush never target the same register in any state, so stall wins trivially.
  always_comb begin
    pc_stall       = 1'b0;
    ifid_stall     = 1'b0;
    idex_stall     = 1'b0;
    exmem_stall    = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    memwb_flush    = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_block) begin
          {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush} = 5'b11111;
        end else if (mdu_block) begin
          {pc_stall, ifid_stall, idex_stall, exmem_flush} = 4'b1111;
        end else if (ex_mispredict) begin
          {ifid_flush, idex_flush} = 2'b11;
        end else if (load_use) begin
          {pc_stall, ifid_stall, idex_flush} = 3'b111;
        end else if (!if_valid) begin
          ifid_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush} = 5'b11111;
      end
      MDU_WAIT: begin
        if (!mdu_done) {pc_stall, ifid_stall, idex_stall, exmem_flush} = 4'b1111;
      end
      REDIR: {redirect_valid, pc_stall, ifid_flush} = 3'b111;
      default: ;
    endcase
  end

  assign redirect_pc  = redirect_pc_q;
  assign stall_cycles = stall_cycles_q;
  assign mdu_tmo_err  = mdu_tmo_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a rule-level model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_pipe_ctrl;

  localparam int PC_W    = 64;
  localparam int RD_W    = 5;
  localparam int MDU_TMO = 4;

  localparam int EV_NONE = 0, EV_MEM = 1, EV_MDU = 2, EV_MISP = 3;
  localparam int EV_LU = 4, EV_BUBBLE = 5, EV_REDIR = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_valid, id_rs1_ren, id_rs2_ren, ex_is_load, ex_mispredict;
  logic ex_mdu_start, mdu_done, mem_req, mem_ready, redirect_ready;
  logic [RD_W-1:0] id_rs1, id_rs2, ex_rd;
  logic [PC_W-1:0] ex_target_pc;
  logic pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0] stall_cycles;
  logic mdu_tmo_err;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Model state: which wait the pipeline is in, described by flags rather than an encoding
  bit m_mem, m_mdu, m_redir, m_err;
  int m_mdu_waited;
  logic [PC_W-1:0] m_rpc;
  logic [31:0] m_stalls;

  always #5 clk = ~clk;

  pipe_ctrl #(.PC_W(PC_W), .RD_W(RD_W), .MDU_TMO(MDU_TMO)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_mispredict(ex_mispredict),
    .ex_target_pc(ex_target_pc), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .mem_req(mem_req), .mem_ready(mem_ready), .redirect_ready(redirect_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_cycles(stall_cycles), .mdu_tmo_err(mdu_tmo_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Control vector order: pc,ifid,idex,exmem stall | ifid,idex,exmem,memwb flush | redirect_valid
  function automatic logic [8:0] ctrl_now();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall,
            ifid_flush, idex_flush, exmem_flush, memwb_flush, redirect_valid};
  endfunction

  function automatic logic [8:0] ctrl_of(input int ev);
    case (ev)
      EV_MEM:    return 9'b1111_0001_0;
      EV_MDU:    return 9'b1110_0010_0;
      EV_MISP:   return 9'b0000_1100_0;
      EV_LU:     return 9'b1100_0100_0;
      EV_BUBBLE: return 9'b0000_1000_0;
      EV_REDIR:  return 9'b1000_1000_1;
      default:   return 9'b0;
    endcase
  endfunction

  function automatic bit model_load_use();
    logic [RD_W-1:0] src [2];
    bit ren [2];
    bit hit = 1'b0;
    src[0] = id_rs1; src[1] = id_rs2;
    ren[0] = id_rs1_ren; ren[1] = id_rs2_ren;
    for (int k = 0; k < 2; k++)
      if (ren[k] && ex_is_load && ex_rd != 0 && src[k] == ex_rd) hit = 1'b1;
    return hit;
  endfunction

  function automatic int classify();
    if (m_redir) return EV_REDIR;
    if (m_mem)   return mem_ready ? EV_NONE : EV_MEM;
    if (m_mdu)   return mdu_done ? EV_NONE : EV_MDU;
    if (mem_req && !mem_ready)      return EV_MEM;
    if (ex_mdu_start && !mdu_done)  return EV_MDU;
    if (ex_mispredict)              return EV_MISP;
    if (model_load_use())           return EV_LU;
    if (!if_valid)                  return EV_BUBBLE;
    return EV_NONE;
  endfunction

  // Compare on the falling edge, then advance the model to what the next rising edge produces
  always @(negedge clk) begin
    int ev;
    logic [8:0] exp_ctrl;
    ev = classify();
    exp_ctrl = ctrl_of(ev);
    if (checking) begin
      checkOutput("ctrl", {55'd0, ctrl_now()}, {55'd0, exp_ctrl});
      checkOutput("redirect_pc", redirect_pc, m_rpc);
      checkOutput("stall_cycles", {32'd0, stall_cycles}, {32'd0, m_stalls});
      checkOutput("mdu_tmo_err", {63'd0, mdu_tmo_err}, {63'd0, m_err});
    end
    if (rst) begin
      m_mem = 0; m_mdu = 0; m_redir = 0; m_err = 0;
      m_mdu_waited = 0; m_rpc = '0; m_stalls = '0;
    end else begin
      if (exp_ctrl[8] && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      if (m_redir) begin
        if (redirect_ready) m_redir = 0;
      end else if (m_mem) begin
        if (mem_ready) m_mem = 0;
      end else if (m_mdu) begin
        if (mdu_done) m_mdu = 0;
        else begin
          m_mdu_waited++;
          if (m_mdu_waited >= MDU_TMO) m_err = 1;
        end
      end else begin
        case (ev)
          EV_MEM:  m_mem = 1;
          EV_MDU:  begin m_mdu = 1; m_mdu_waited = 0; end
          EV_MISP: begin m_redir = 1; m_rpc = ex_target_pc; end
          default: ;
        endcase
      end
    end
  end

  task automatic applyStimulus(input bit ifv, input bit ld, input logic [RD_W-1:0] rd,
                               input logic [RD_W-1:0] rs1, input bit r1en, input bit misp,
                               input logic [PC_W-1:0] tpc, input bit mst, input bit mdone,
                               input bit mreq, input bit mrdy, input bit rrdy);
    if_valid = ifv; ex_is_load = ld; ex_rd = rd; id_rs1 = rs1; id_rs1_ren = r1en;
    id_rs2 = '0; id_rs2_ren = 1'b0;
    ex_mispredict = misp; ex_target_pc = tpc; ex_mdu_start = mst; mdu_done = mdone;
    mem_req = mreq; mem_ready = mrdy; redirect_ready = rrdy;
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic doReset();
    cycle(); rst = 1'b1; idle();
    cycle(); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;
    mid();
    checkOutput("rst_ctrl", {55'd0, ctrl_now()}, 64'd0);
    checkOutput("rst_pc", redirect_pc, 64'd0);
    checkOutput("rst_stalls", {32'd0, stall_cycles}, 64'd0);
    checkOutput("rst_err", {63'd0, mdu_tmo_err}, 64'd0);

    // Load-use via rs1, rs2, then non-hazard variants
    cycle(); applyStimulus(1, 1, 5, 5, 1, 0, '0, 0, 0, 0, 0, 0);
    mid();   checkOutput("lu_rs1", {55'd0, ctrl_now()}, {55'd0, 9'b1100_0100_0});
    cycle(); applyStimulus(1, 1, 0, 0, 1, 0, '0, 0, 0, 0, 0, 0);
    mid();   checkOutput("lu_x0", {55'd0, ctrl_now()}, 64'd0);
    cycle(); applyStimulus(1, 1, 7, 3, 1, 0, '0, 0, 0, 0, 0, 0); id_rs2 = 7; id_rs2_ren = 1;
    mid();   checkOutput("lu_rs2", {55'd0, ctrl_now()}, {55'd0, 9'b1100_0100_0});
    cycle(); applyStimulus(1, 1, 5, 5, 0, 0, '0, 0, 0, 0, 0, 0);
    mid();   checkOutput("lu_noren", {55'd0, ctrl_now()}, 64'd0);
    cycle(); applyStimulus(0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
    mid();   checkOutput("bubble", {55'd0, ctrl_now()}, {55'd0, 9'b0000_1000_0});
    cycle(); idle();
    mid();   checkOutput("lu_stalls", {32'd0, stall_cycles}, 64'd2);

    // Memory wait: four not-ready cycles then ready
    doReset();
    for (int i = 0; i < 5; i++) begin
      cycle(); applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, 0, 1, (i == 4), 0);
      mid();
      if (i == 0) checkOutput("mem_freeze", {55'd0, ctrl_now()}, {55'd0, 9'b1111_0001_0});
      if (i == 4) checkOutput("mem_release", {55'd0, ctrl_now()}, 64'd0);
    end
    cycle(); idle();
    mid();   checkOutput("mem_stalls", {32'd0, stall_cycles}, 64'd4);

    // Mispredict and redirect handshake with two not-ready cycles
    doReset();
    cycle(); applyStimulus(1, 0, 0, 0, 0, 1, 64'h8000_0100, 0, 0, 0, 0, 0);
    mid();   checkOutput("misp_flush", {55'd0, ctrl_now()}, {55'd0, 9'b0000_1100_0});
    for (int i = 0; i < 3; i++) begin
      cycle(); applyStimulus(1, 0, 0, 0, 0, 0, 64'hDEAD_BEEF, 0, 0, 0, 0, (i == 2));
      mid();
      checkOutput("redir_valid", {63'd0, redirect_valid}, 64'd1);
      checkOutput("redir_pc", redirect_pc, 64'h8000_0100);
    end
    cycle(); idle();
    mid();   checkOutput("redir_done", {55'd0, ctrl_now()}, 64'd0);

    // MDU: short op without timeout, then a 10-cycle op that trips the timeout
    doReset();
    for (int i = 0; i < 3; i++) begin
      cycle(); applyStimulus(1, 0, 0, 0, 0, 0, '0, 1, (i == 2), 0, 0, 0);
    end
    cycle(); idle();
    mid();   checkOutput("mdu_short_err", {63'd0, mdu_tmo_err}, 64'd0);
    checkOutput("mdu_short_stalls", {32'd0, stall_cycles}, 64'd2);
    for (int i = 0; i < 11; i++) begin
      cycle(); applyStimulus(1, 0, 0, 0, 0, 0, '0, 1, (i == 10), 0, 0, 0);
      mid();
      if (i == 1)  checkOutput("mdu_freeze", {55'd0, ctrl_now()}, {55'd0, 9'b1110_0010_0});
      if (i == 4)  checkOutput("mdu_err_pre", {63'd0, mdu_tmo_err}, 64'd0);
      if (i == 5)  checkOutput("mdu_err_set", {63'd0, mdu_tmo_err}, 64'd1);
      if (i == 10) checkOutput("mdu_release", {55'd0, ctrl_now()}, 64'd0);
    end
    cycle(); idle();
    mid();   checkOutput("mdu_stalls", {32'd0, stall_cycles}, 64'd12);
    checkOutput("mdu_err_sticky", {63'd0, mdu_tmo_err}, 64'd1);

    // Priority: mem wait beats mispredict and load-use; mispredict is serviced afterwards
    doReset();
    cycle(); applyStimulus(1, 1, 5, 5, 1, 1, 64'h8000_0200, 0, 0, 1, 0, 0);
    mid();   checkOutput("prio_mem", {55'd0, ctrl_now()}, {55'd0, 9'b1111_0001_0});
    cycle(); applyStimulus(1, 1, 5, 5, 1, 1, 64'h8000_0200, 0, 0, 1, 1, 0);
    mid();   checkOutput("prio_release", {55'd0, ctrl_now()}, 64'd0);
    cycle(); applyStimulus(1, 1, 5, 5, 1, 1, 64'h8000_0200, 0, 0, 0, 0, 0);
    mid();   checkOutput("prio_misp", {55'd0, ctrl_now()}, {55'd0, 9'b0000_1100_0});
    cycle(); applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 1);
    mid();   checkOutput("prio_redir_pc", redirect_pc, 64'h8000_0200);
    checkOutput("prio_redir", {55'd0, ctrl_now()}, {55'd0, 9'b1000_1000_1});

    // Reset while a redirect is pending
    doReset();
    cycle(); applyStimulus(1, 0, 0, 0, 0, 1, 64'h8000_0300, 0, 0, 0, 0, 0);
    cycle(); idle(); rst = 1'b1;
    mid();   checkOutput("rst_redir_pre", {63'd0, redirect_valid}, 64'd1);
    cycle(); rst = 1'b0;
    mid();   checkOutput("rst_redir_valid", {63'd0, redirect_valid}, 64'd0);
    checkOutput("rst_redir_stalls", {32'd0, stall_cycles}, 64'd0);
    checkOutput("rst_redir_pc", redirect_pc, 64'd0);

    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
